// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the piRISC RV32I core.
// Sequences FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK] over a
// single-ported memory and drives all datapath selects and write strobes.
// Ports:
//   clk, reset (async active-low), go_contr (start, sampled in IDLE)
//   ir        : instruction register contents
//   mem_ack   : memory completion (ignored while mem_req=0)
//   br_taken  : branch compare result (EXECUTE)
//   state     : IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 MEMORY=4 WRITEBACK=5 HALT=6
//   mem_req/mem_we/mem_sel_pc, ir_load, pc_write/pc_src,
//   alu_a_sel/alu_b_sel, rf_write/wb_sel : datapath controls
//   halted/illegal/err_timeout : sticky status, instr_count : retired count
module core_sequencer #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go_contr,
  input  logic [31:0]      ir,
  input  logic             mem_ack,
  input  logic             br_taken,
  output logic [2:0]       state,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel_pc,
  output logic             ir_load,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic             rf_write,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic             illegal,
  output logic             err_timeout,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  state_t              cur, nxt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                timeout_hit;
  logic                retire;

  logic [6:0] opcode;
  logic op_r, op_i, op_ld, op_st, op_br, op_jal, op_jalr, op_lui, op_auipc;
  logic op_legal, halt_word;

  assign opcode    = ir[6:0];
  assign op_r      = (opcode == 7'b0110011);
  assign op_i      = (opcode == 7'b0010011);
  assign op_ld     = (opcode == 7'b0000011);
  assign op_st     = (opcode == 7'b0100011);
  assign op_br     = (opcode == 7'b1100011);
  assign op_jal    = (opcode == 7'b1101111);
  assign op_jalr   = (opcode == 7'b1100111);
  assign op_lui    = (opcode == 7'b0110111);
  assign op_auipc  = (opcode == 7'b0010111);
  assign op_legal  = op_r | op_i | op_ld | op_st | op_br | op_jal | op_jalr | op_lui | op_auipc;
  assign halt_word = (ir == 32'hFFFF_FFFF);

  assign state = cur;

  // A wait cycle that would bring the counter to TIMEOUT ends the run,
  // unless the ack arrives in that same cycle.
  assign timeout_hit = mem_req & ~mem_ack & (wait_cnt == WAIT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= S_IDLE;
    else        cur <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:      if (go_contr) nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ack)          nxt = S_DECODE;
        else if (timeout_hit) nxt = S_HALT;
      end
      S_DECODE:    nxt = (halt_word || !op_legal) ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
        if (op_br)               nxt = S_FETCH;
        else if (op_ld || op_st) nxt = S_MEMORY;
        else                     nxt = S_WRITEBACK;
      end
      S_MEMORY: begin
        if (mem_ack)          nxt = op_st ? S_FETCH : S_WRITEBACK;
        else if (timeout_hit) nxt = S_HALT;
      end
      S_WRITEBACK: nxt = S_FETCH;
      S_HALT:      nxt = S_HALT;
      default:     nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_sel_pc = 1'b0;
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_a_sel  = 1'b0;
    alu_b_sel  = 1'b0;
    rf_write   = 1'b0;
    wb_sel     = 2'b00;
    retire     = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_req    = 1'b1;
        mem_sel_pc = 1'b1;
        ir_load    = mem_ack;
      end
      S_EXECUTE: begin
        alu_a_sel = op_auipc | op_jal;
        alu_b_sel = ~(op_r | op_br);
        if (op_br) begin
          pc_write = 1'b1;
          pc_src   = br_taken ? 2'b01 : 2'b00;
          retire   = 1'b1;
        end
      end
      S_MEMORY: begin
        mem_req = 1'b1;
        mem_we  = op_st;
        if (op_st && mem_ack) begin
          pc_write = 1'b1;
          retire   = 1'b1;
        end
      end
      S_WRITEBACK: begin
        rf_write = 1'b1;
        pc_write = 1'b1;
        retire   = 1'b1;
        if (op_ld)                 wb_sel = 2'b01;
        else if (op_jal | op_jalr) wb_sel = 2'b10;
        if (op_jal)       pc_src = 2'b01;
        else if (op_jalr) pc_src = 2'b10;
      end
      default: ;
    endcase
  end

  // Wait counter, sticky status and retired-instruction counter.
  // Clearing whenever the current cycle is not an unacked request cycle is
  // equivalent to clearing on each entry to FETCH/MEMORY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt    <= '0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      err_timeout <= 1'b0;
      instr_count <= '0;
    end else begin
      if (mem_req && !mem_ack && !timeout_hit) wait_cnt <= wait_cnt + 1'b1;
      else                                     wait_cnt <= '0;
      if (nxt == S_HALT && cur != S_HALT) begin
        halted <= 1'b1;
        if (cur == S_DECODE && !halt_word && !op_legal) illegal <= 1'b1;
        if (timeout_hit) err_timeout <= 1'b1;
      end
      if (retire) instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset, go_contr, mem_ack, br_taken;
  logic [31:0] ir;
  logic [2:0]  state;
  logic        mem_req, mem_we, mem_sel_pc, ir_load, pc_write;
  logic [1:0]  pc_src;
  logic        alu_a_sel, alu_b_sel, rf_write;
  logic [1:0]  wb_sel;
  logic        halted, illegal, err_timeout;
  logic [1:0]  instr_count;

  always #5 clk = ~clk;

  core_sequencer #(.CNT_W(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .go_contr(go_contr), .ir(ir),
    .mem_ack(mem_ack), .br_taken(br_taken), .state(state),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel_pc(mem_sel_pc),
    .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .rf_write(rf_write),
    .wb_sel(wb_sel), .halted(halted), .illegal(illegal),
    .err_timeout(err_timeout), .instr_count(instr_count)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, selpc, irl, pcw;
    logic [1:0] pcs;
    logic       aa, ab, rfw;
    logic [1:0] wbs;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cycles = 0;
  int   m_count = 0;
  logic m_halted = 1'b0, m_illegal = 1'b0, m_to = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare everything at the falling edge
  // against the model, then advance the model past the rising edge.
  task automatic step(input exp_t e, input logic ack, input logic br, input logic ret);
    exp_t act;
    mem_ack  = ack;
    br_taken = br;
    @(negedge clk);
    act.st = state; act.req = mem_req; act.we = mem_we; act.selpc = mem_sel_pc;
    act.irl = ir_load; act.pcw = pc_write; act.pcs = pc_src;
    act.aa = alu_a_sel; act.ab = alu_b_sel; act.rfw = rf_write; act.wbs = wb_sel;
    check($sformatf("outputs st=%0d", e.st), 32'(act), 32'(e));
    check($sformatf("flags st=%0d", e.st), 32'({halted, illegal, err_timeout}),
          32'({m_halted, m_illegal, m_to}));
    check($sformatf("count st=%0d", e.st), 32'(instr_count), 32'(m_count % 4));
    @(posedge clk);
    #1;
    cycles++;
    if (ret) m_count = (m_count + 1) % 4;
  endtask

  function automatic exp_t only_state(input logic [2:0] st);
    exp_t e = '0;
    e.st = st;
    return e;
  endfunction

  // Builds the expected cycle sequence of one instruction from the opcode rules.
  task automatic run_instr(input logic [31:0] instr, input int fw, input int mw,
                           input logic br, input logic stray);
    logic [6:0] op;
    logic is_r, is_i, is_ld, is_st, is_b, is_jal, is_jalr, is_lui, is_auipc, legal;
    exp_t e;
    op = instr[6:0];
    is_r = (op == 7'h33); is_i = (op == 7'h13); is_ld = (op == 7'h03);
    is_st = (op == 7'h23); is_b = (op == 7'h63); is_jal = (op == 7'h6F);
    is_jalr = (op == 7'h67); is_lui = (op == 7'h37); is_auipc = (op == 7'h17);
    legal = is_r | is_i | is_ld | is_st | is_b | is_jal | is_jalr | is_lui | is_auipc;
    ir = instr;
    cycles = 0;
    for (int k = 0; k < fw; k++) begin
      e = only_state(3'd1); e.req = 1'b1; e.selpc = 1'b1;
      step(e, 1'b0, 1'b0, 1'b0);
    end
    e = only_state(3'd1); e.req = 1'b1; e.selpc = 1'b1; e.irl = 1'b1;
    step(e, 1'b1, 1'b0, 1'b0);
    step(only_state(3'd2), stray, 1'b0, 1'b0);
    if (instr == 32'hFFFF_FFFF) begin m_halted = 1'b1; return; end
    if (!legal) begin m_halted = 1'b1; m_illegal = 1'b1; return; end
    e = only_state(3'd3);
    e.aa = is_auipc | is_jal;
    e.ab = !(is_r | is_b);
    if (is_b) begin e.pcw = 1'b1; e.pcs = br ? 2'b01 : 2'b00; end
    step(e, stray, br, is_b);
    if (is_b) return;
    if (is_ld | is_st) begin
      for (int k = 0; k < mw; k++) begin
        e = only_state(3'd4); e.req = 1'b1; e.we = is_st;
        step(e, 1'b0, 1'b0, 1'b0);
      end
      e = only_state(3'd4); e.req = 1'b1; e.we = is_st; e.pcw = is_st;
      step(e, 1'b1, 1'b0, is_st);
      if (is_st) return;
    end
    e = only_state(3'd5);
    e.rfw = 1'b1;
    e.wbs = is_ld ? 2'b01 : ((is_jal | is_jalr) ? 2'b10 : 2'b00);
    e.pcw = 1'b1;
    e.pcs = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
    step(e, stray, 1'b0, 1'b1);
  endtask

  task automatic halt_cycles(input int n);
    for (int k = 0; k < n; k++) step(only_state(3'd6), 1'b1, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m_count = 0; m_halted = 1'b0; m_illegal = 1'b0; m_to = 1'b0;
    step(only_state(3'd0), 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step(only_state(3'd0), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    exp_t e;
    reset = 1'b0; go_contr = 1'b0; mem_ack = 1'b0; br_taken = 1'b0; ir = '0;
    #1;
    step(only_state(3'd0), 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    // Stray ack in IDLE without go: no movement.
    step(only_state(3'd0), 1'b1, 1'b0, 1'b0);
    go_contr = 1'b1;
    step(only_state(3'd0), 1'b0, 1'b0, 1'b0);

    run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0);          // ADD
    check("add cycles", 32'(cycles), 32'd4);
    check("add count", 32'(instr_count), 32'd1);
    check("add next fetch", 32'(state), 32'd1);
    run_instr(32'h0000A103, 1, 1, 1'b0, 1'b0);          // LW, 2-cycle acks
    check("lw cycles", 32'(cycles), 32'd7);
    run_instr(32'h00208463, 0, 0, 1'b1, 1'b0);          // BEQ taken
    check("beq taken cycles", 32'(cycles), 32'd3);
    run_instr(32'h00208463, 0, 0, 1'b0, 1'b0);          // BEQ not taken
    check("beq count wrap", 32'(instr_count), 32'd0);
    run_instr(32'h0020A023, TMO - 1, 0, 1'b0, 1'b0);    // SW, ack on last allowed cycle
    check("five retires CNT_W=2", 32'(instr_count), 32'd1);
    run_instr(32'h00108093, 0, 0, 1'b0, 1'b1);          // ADDI with stray acks
    run_instr(32'h000010B7, 0, 0, 1'b0, 1'b0);          // LUI
    run_instr(32'h00001097, 0, 0, 1'b0, 1'b0);          // AUIPC
    run_instr(32'h008000EF, 0, 0, 1'b0, 1'b1);          // JAL
    run_instr(32'h000080E7, 0, 0, 1'b0, 1'b0);          // JALR
    run_instr(32'h0020A023, 0, TMO - 1, 1'b0, 1'b0);    // SW, late memory ack
    check("sw late cycles", 32'(cycles), 32'd7);
    check("count before reset", 32'(instr_count), 32'd3);

    // Reset in the middle of a MEMORY wait.
    ir = 32'h0000A103;
    e = only_state(3'd1); e.req = 1'b1; e.selpc = 1'b1; e.irl = 1'b1;
    step(e, 1'b1, 1'b0, 1'b0);
    step(only_state(3'd2), 1'b0, 1'b0, 1'b0);
    e = only_state(3'd3); e.ab = 1'b1;
    step(e, 1'b0, 1'b0, 1'b0);
    e = only_state(3'd4); e.req = 1'b1;
    step(e, 1'b0, 1'b0, 1'b0);
    #2;
    check("mid memory state", 32'(state), 32'd4);
    check("mid memory req", 32'(mem_req), 32'd1);
    reset = 1'b0;
    #1;
    check("async reset req", 32'(mem_req), 32'd0);
    check("async reset state", 32'(state), 32'd0);
    check("async reset count", 32'(instr_count), 32'd0);
    m_count = 0; m_halted = 1'b0; m_illegal = 1'b0; m_to = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(only_state(3'd0), 1'b0, 1'b0, 1'b0);

    run_instr(32'h0000007F, 0, 0, 1'b0, 1'b0);          // illegal opcode
    halt_cycles(3);
    check("illegal flag", 32'(illegal), 32'd1);
    check("illegal halted", 32'(halted), 32'd1);

    do_reset();
    run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0);
    run_instr(32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);         // halt word
    halt_cycles(3);
    check("halt word illegal", 32'(illegal), 32'd0);
    check("halt word count", 32'(instr_count), 32'd1);

    do_reset();
    ir = 32'h002081B3;
    cycles = 0;
    for (int k = 0; k < TMO; k++) begin
      e = only_state(3'd1); e.req = 1'b1; e.selpc = 1'b1;
      step(e, 1'b0, 1'b0, 1'b0);
    end
    m_halted = 1'b1; m_to = 1'b1;
    check("timeout request cycles", 32'(cycles), 32'd4);
    check("timeout flag", 32'(err_timeout), 32'd1);
    check("timeout state", 32'(state), 32'd6);
    halt_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
